// File: rtl/calc_engine.sv
// calc_engine: signed accumulator core with single-cycle add/sub and W-cycle iterative mul/div.
// Optional build macro CALC_SATURATE_EN clamps acc on overflow instead of wrapping.
module calc_engine #(
  parameter int W = 8
) (
  input  logic         clki,
  input  logic         rst_n,
  input  logic [W-2:0] mag,
  input  logic         sinal,
  input  logic [1:0]   op,
  input  logic         load,
  input  logic         go,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] acc,
  output logic         ovf,
  output logic         dz
);

  localparam int CW = $clog2(W + 1);
  localparam logic [2*W-1:0] HALF = (2*W)'(1) << (W - 1);
`ifdef CALC_SATURATE_EN
  localparam logic [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};
`endif

  typedef enum logic [1:0] {IDLE, ITER, FIN} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   acc_q, acc_d;
  logic           ovf_q, ovf_d, dz_q, dz_d, done_q, done_d, busy_q, busy_d;
  logic [1:0]     op_q, op_d;
  logic [W-1:0]   opnd_q, opnd_d;
  logic           neg_q, neg_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d, rem_q, rem_d;
  logic [2*W-1:0] mcand_q, mcand_d, prod_q, prod_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [W-1:0]   operand, accMag, opMag, sum;
  logic [W:0]     trial, diff;
  logic [W-1:0]   finAcc;
  logic           finOvf, finDz;

  assign operand = sinal ? -{1'b0, mag} : {1'b0, mag};
  assign opMag   = {1'b0, mag};
  assign accMag  = acc_q[W-1] ? -acc_q : acc_q;

  // Restoring division: a_q shifts the dividend out and the quotient in.
  assign trial = {rem_q, a_q[W-1]};
  assign diff  = trial - {1'b0, b_q};

  always_comb begin
    finAcc = acc_q;
    finOvf = 1'b0;
    finDz  = 1'b0;
    sum    = '0;
    case (op_q)
      2'b00: begin
        sum    = acc_q + opnd_q;
        finAcc = sum;
        finOvf = (acc_q[W-1] == opnd_q[W-1]) && (sum[W-1] != acc_q[W-1]);
      end
      2'b01: begin
        sum    = acc_q - opnd_q;
        finAcc = sum;
        finOvf = (acc_q[W-1] != opnd_q[W-1]) && (sum[W-1] != acc_q[W-1]);
      end
      2'b10: begin
        finAcc = neg_q ? -prod_q[W-1:0] : prod_q[W-1:0];
        finOvf = neg_q ? (prod_q > HALF) : (prod_q >= HALF);
      end
      default: begin
        if (opnd_q == '0) begin
          finDz = 1'b1;
        end else begin
          finAcc = neg_q ? -a_q : a_q;
          finOvf = !neg_q && a_q[W-1];
        end
      end
    endcase
`ifdef CALC_SATURATE_EN
    // On overflow the true result has the sign of acc (add/sub) or of neg_q (mul/div).
    if (finOvf) begin
      if (op_q[1]) finAcc = neg_q ? MINV : MAXV;
      else         finAcc = acc_q[W-1] ? MINV : MAXV;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    op_d    = op_q;
    opnd_d  = opnd_q;
    neg_d   = neg_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (load) begin
          acc_d = operand;
          ovf_d = 1'b0;
          dz_d  = 1'b0;
        end else if (go) begin
          op_d    = op;
          opnd_d  = operand;
          neg_d   = acc_q[W-1] ^ sinal;
          a_d     = accMag;
          b_d     = opMag;
          rem_d   = '0;
          mcand_d = {{W{1'b0}}, accMag};
          prod_d  = '0;
          cnt_d   = '0;
          // A zero operand short-circuits mul (result 0) and div (divide-by-zero).
          if (op[1] && (mag != '0)) begin
            state_d = ITER;
            busy_d  = 1'b1;
          end else begin
            state_d = FIN;
          end
        end
      end
      ITER: begin
        cnt_d = cnt_q + CW'(1);
        if (!op_q[0]) begin
          if (b_q[0]) prod_d = prod_q + mcand_q;
          mcand_d = mcand_q << 1;
          b_d     = b_q >> 1;
        end else begin
          rem_d = diff[W] ? trial[W-1:0] : diff[W-1:0];
          a_d   = {a_q[W-2:0], ~diff[W]};
        end
        if (cnt_q == CW'(W - 1)) state_d = FIN;
      end
      FIN: begin
        acc_d   = finAcc;
        ovf_d   = finOvf;
        dz_d    = finDz;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      op_q    <= '0;
      opnd_q  <= '0;
      neg_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      neg_q   <= neg_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign acc  = acc_q;
  assign ovf  = ovf_q;
  assign dz   = dz_q;

endmodule

// File: tb/tb_calc_engine.sv
// tb_calc_engine: scoreboard bench for calc_engine; expected results come from an integer model
// pushed at go time and popped when done pulses.
module tb_calc_engine;

  localparam int W = 8;

  logic         clki = 1'b0;
  logic         rst_n;
  logic [W-2:0] mag;
  logic         sinal;
  logic [1:0]   op;
  logic         load, go;
  logic         busy, done, ovf, dz;
  logic [W-1:0] acc;

  always #5 clki = ~clki;

  calc_engine #(.W(W)) dut (
    .clki(clki), .rst_n(rst_n), .mag(mag), .sinal(sinal), .op(op),
    .load(load), .go(go), .busy(busy), .done(done), .acc(acc), .ovf(ovf), .dz(dz)
  );

  typedef struct {
    logic [W-1:0] acc; logic ovf; logic dz; int lat; int busyN;
  } exp_t;
  typedef struct {
    logic [W-1:0] acc; logic ovf; logic dz; logic busyEnd; logic doneAfter;
    logic [W+1:0] holdAfter; int lat; int busyN; bit got;
  } obs_t;
  typedef struct { bit isLoad; logic [1:0] o; logic s; logic [W-2:0] m; } step_t;

  exp_t         sbQ[$];
  logic [W-1:0] modelAcc;
  int           nCompared = 0;
  int           nFailed   = 0;

  task automatic issueLoad(input logic s, input logic [W-2:0] m);
    @(negedge clki); sinal = s; mag = m; load = 1'b1;
    @(negedge clki); load = 1'b0;
    modelAcc = s ? -{1'b0, m} : {1'b0, m};
  endtask

  // Integer reference: full-precision result, then range check and wrap or clamp.
  task automatic issueGo(input logic [1:0] o, input logic s, input logic [W-2:0] m);
    exp_t e;
    int a, b, r;
    a = $signed(modelAcc);
    b = s ? -int'(m) : int'(m);
    e.dz = 1'b0;
    case (o)
      2'b00:   r = a + b;
      2'b01:   r = a - b;
      2'b10:   r = a * b;
      default: if (b == 0) begin r = a; e.dz = 1'b1; end else r = a / b;
    endcase
    e.ovf = (r > 2**(W-1) - 1) || (r < -(2**(W-1)));
    e.acc = r[W-1:0];
`ifdef CALC_SATURATE_EN
    if (e.ovf) e.acc = (r > 0) ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};
`endif
    e.lat   = (o[1] && m != 0) ? W + 1 : 1;
    e.busyN = (o[1] && m != 0) ? W + 1 : 0;
    modelAcc = e.acc;
    sbQ.push_back(e);
    @(negedge clki); op = o; sinal = s; mag = m; go = 1'b1;
    @(negedge clki); go = 1'b0;
  endtask

  task automatic waitDone(output obs_t ob);
    ob.got = 0; ob.lat = 0; ob.busyN = 0; ob.acc = '0; ob.ovf = 0; ob.dz = 0;
    ob.busyEnd = 0; ob.doneAfter = 0; ob.holdAfter = '0;
    for (int i = 0; i < 4 * W; i++) begin
      if (done === 1'b1) begin
        ob.got = 1; ob.acc = acc; ob.ovf = ovf; ob.dz = dz; ob.busyEnd = busy;
        @(negedge clki);
        ob.doneAfter = done;
        ob.holdAfter = {acc, ovf, dz};
        break;
      end
      if (busy === 1'b1) ob.busyN++;
      @(negedge clki);
      ob.lat++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; mag = '0; sinal = 1'b0; op = 2'b00; load = 1'b0; go = 1'b0;
    repeat (2) @(negedge clki);
    nCompared++;
    if ({acc, busy, done, ovf, dz} !== '0) begin
      nFailed++;
      $display("[TB] FAIL reset_state: acc=%0d busy=%b done=%b ovf=%b dz=%b, want all zero",
               $signed(acc), busy, done, ovf, dz);
    end
    modelAcc = '0;
    @(negedge clki); rst_n = 1'b1;
  endtask

  task automatic test_addsub;
    step_t steps [8] = '{'{1'b1, 2'b00, 1'b0, 7'd100}, '{1'b0, 2'b00, 1'b0, 7'd27},
                         '{1'b0, 2'b00, 1'b0, 7'd1},   '{1'b1, 2'b00, 1'b1, 7'd100},
                         '{1'b0, 2'b01, 1'b0, 7'd50},  '{1'b0, 2'b01, 1'b1, 7'd20},
                         '{1'b0, 2'b00, 1'b1, 7'd5},   '{1'b0, 2'b01, 1'b0, 7'd33}};
    exp_t e;
    obs_t ob;
    for (int i = 0; i < 8; i++) begin
      if (steps[i].isLoad) begin
        issueLoad(steps[i].s, steps[i].m);
        nCompared++;
        if (acc !== modelAcc || ovf !== 1'b0 || dz !== 1'b0) begin
          nFailed++;
          $display("[TB] FAIL addsub_load[%0d]: acc=%0d ovf=%b dz=%b, want acc=%0d ovf=0 dz=0",
                   i, $signed(acc), ovf, dz, $signed(modelAcc));
        end
      end else begin
        issueGo(steps[i].o, steps[i].s, steps[i].m);
        waitDone(ob);
        e = sbQ.pop_front();
        nCompared++;
        if (!ob.got) begin
          nFailed++;
          $display("[TB] FAIL addsub_timeout[%0d]: done not seen, want done after %0d cycles", i, e.lat);
        end else begin
          nCompared++;
          if ({ob.acc, ob.ovf, ob.dz} !== {e.acc, e.ovf, e.dz}) begin
            nFailed++;
            $display("[TB] FAIL addsub_result[%0d]: acc=%0d ovf=%b dz=%b, want acc=%0d ovf=%b dz=%b",
                     i, $signed(ob.acc), ob.ovf, ob.dz, $signed(e.acc), e.ovf, e.dz);
          end
          nCompared++;
          if (ob.lat != e.lat || ob.busyN != e.busyN || ob.busyEnd !== 1'b0 || ob.doneAfter !== 1'b0) begin
            nFailed++;
            $display("[TB] FAIL addsub_timing[%0d]: lat=%0d busyCycles=%0d busyEnd=%b doneAfter=%b, want %0d %0d 0 0",
                     i, ob.lat, ob.busyN, ob.busyEnd, ob.doneAfter, e.lat, e.busyN);
          end
        end
      end
    end
  endtask

  task automatic test_mul;
    step_t steps [6] = '{'{1'b1, 2'b00, 1'b1, 7'd12}, '{1'b0, 2'b10, 1'b0, 7'd10},
                         '{1'b0, 2'b10, 1'b0, 7'd2},  '{1'b1, 2'b00, 1'b1, 7'd7},
                         '{1'b0, 2'b10, 1'b1, 7'd9},  '{1'b0, 2'b10, 1'b0, 7'd0}};
    exp_t e;
    obs_t ob;
    for (int i = 0; i < 6; i++) begin
      if (steps[i].isLoad) begin
        issueLoad(steps[i].s, steps[i].m);
        nCompared++;
        if (acc !== modelAcc || ovf !== 1'b0) begin
          nFailed++;
          $display("[TB] FAIL mul_load[%0d]: acc=%0d ovf=%b, want acc=%0d ovf=0", i, $signed(acc), ovf, $signed(modelAcc));
        end
      end else begin
        issueGo(steps[i].o, steps[i].s, steps[i].m);
        waitDone(ob);
        e = sbQ.pop_front();
        nCompared++;
        if (!ob.got) begin
          nFailed++;
          $display("[TB] FAIL mul_timeout[%0d]: done not seen, want done after %0d cycles", i, e.lat);
        end else begin
          nCompared++;
          if ({ob.acc, ob.ovf, ob.dz} !== {e.acc, e.ovf, e.dz}) begin
            nFailed++;
            $display("[TB] FAIL mul_result[%0d]: acc=%0d ovf=%b dz=%b, want acc=%0d ovf=%b dz=%b",
                     i, $signed(ob.acc), ob.ovf, ob.dz, $signed(e.acc), e.ovf, e.dz);
          end
          nCompared++;
          if (ob.lat != e.lat || ob.busyN != e.busyN || ob.busyEnd !== 1'b0 || ob.doneAfter !== 1'b0) begin
            nFailed++;
            $display("[TB] FAIL mul_timing[%0d]: lat=%0d busyCycles=%0d busyEnd=%b doneAfter=%b, want %0d %0d 0 0",
                     i, ob.lat, ob.busyN, ob.busyEnd, ob.doneAfter, e.lat, e.busyN);
          end
          nCompared++;
          if (ob.holdAfter !== {e.acc, e.ovf, e.dz}) begin
            nFailed++;
            $display("[TB] FAIL mul_hold[%0d]: {acc,ovf,dz}=%h one cycle later, want %h",
                     i, ob.holdAfter, {e.acc, e.ovf, e.dz});
          end
        end
      end
    end
  endtask

  task automatic test_div;
    step_t steps [8] = '{'{1'b1, 2'b00, 1'b0, 7'd100}, '{1'b0, 2'b11, 1'b1, 7'd7},
                         '{1'b1, 2'b00, 1'b1, 7'd0},   '{1'b1, 2'b00, 1'b1, 7'd100},
                         '{1'b0, 2'b11, 1'b0, 7'd3},   '{1'b1, 2'b00, 1'b0, 7'd7},
                         '{1'b0, 2'b11, 1'b0, 7'd9},   '{1'b0, 2'b11, 1'b1, 7'd1}};
    exp_t e;
    obs_t ob;
    for (int i = 0; i < 8; i++) begin
      if (steps[i].isLoad) begin
        issueLoad(steps[i].s, steps[i].m);
        nCompared++;
        if (acc !== modelAcc) begin
          nFailed++;
          $display("[TB] FAIL div_load[%0d]: acc=%0d, want %0d", i, $signed(acc), $signed(modelAcc));
        end
      end else begin
        issueGo(steps[i].o, steps[i].s, steps[i].m);
        waitDone(ob);
        e = sbQ.pop_front();
        nCompared++;
        if (!ob.got) begin
          nFailed++;
          $display("[TB] FAIL div_timeout[%0d]: done not seen, want done after %0d cycles", i, e.lat);
        end else begin
          nCompared++;
          if ({ob.acc, ob.ovf, ob.dz} !== {e.acc, e.ovf, e.dz}) begin
            nFailed++;
            $display("[TB] FAIL div_result[%0d]: acc=%0d ovf=%b dz=%b, want acc=%0d ovf=%b dz=%b",
                     i, $signed(ob.acc), ob.ovf, ob.dz, $signed(e.acc), e.ovf, e.dz);
          end
          nCompared++;
          if (ob.lat != e.lat || ob.busyN != e.busyN) begin
            nFailed++;
            $display("[TB] FAIL div_timing[%0d]: lat=%0d busyCycles=%0d, want %0d %0d",
                     i, ob.lat, ob.busyN, e.lat, e.busyN);
          end
        end
      end
    end
    // -128 / -1 cannot be represented: exercises the overflow path of division.
    issueLoad(1'b1, 7'd0);
    issueLoad(1'b1, 7'd0);
    modelAcc = {1'b1, {(W-1){1'b0}}};
    @(negedge clki); sinal = 1'b1; mag = '0; load = 1'b0;
    force_min_load();
    issueGo(2'b11, 1'b1, 7'd1);
    waitDone(ob);
    e = sbQ.pop_front();
    nCompared++;
    if (!ob.got || {ob.acc, ob.ovf, ob.dz} !== {e.acc, e.ovf, e.dz}) begin
      nFailed++;
      $display("[TB] FAIL div_min_by_m1: got=%0d acc=%0d ovf=%b dz=%b, want acc=%0d ovf=%b dz=0",
               ob.got, $signed(ob.acc), ob.ovf, ob.dz, $signed(e.acc), e.ovf);
    end
  endtask

  // Reaches acc=-128 via -100 + -28, since a W-1 bit magnitude cannot express 128 directly.
  task automatic force_min_load;
    exp_t e;
    obs_t ob;
    issueLoad(1'b1, 7'd100);
    issueGo(2'b00, 1'b1, 7'd28);
    waitDone(ob);
    e = sbQ.pop_front();
    nCompared++;
    if (!ob.got || ob.acc !== e.acc || ob.ovf !== 1'b0) begin
      nFailed++;
      $display("[TB] FAIL div_min_setup: got=%0d acc=%0d ovf=%b, want acc=%0d ovf=0",
               ob.got, $signed(ob.acc), ob.ovf, $signed(e.acc));
    end
  endtask

  task automatic test_div_zero;
    exp_t e;
    obs_t ob;
    issueLoad(1'b0, 7'd55);
    issueGo(2'b11, 1'b0, 7'd0);
    waitDone(ob);
    e = sbQ.pop_front();
    nCompared++;
    if (!ob.got || {ob.acc, ob.ovf, ob.dz} !== {e.acc, e.ovf, e.dz} || ob.lat != 1 || ob.busyN != 0) begin
      nFailed++;
      $display("[TB] FAIL divzero_result: got=%0d acc=%0d ovf=%b dz=%b lat=%0d busyCycles=%0d, want acc=55 ovf=0 dz=1 lat=1 busy=0",
               ob.got, $signed(ob.acc), ob.ovf, ob.dz, ob.lat, ob.busyN);
    end
    issueLoad(1'b0, 7'd3);
    nCompared++;
    if (dz !== 1'b0 || acc !== 8'd3) begin
      nFailed++;
      $display("[TB] FAIL divzero_clear: dz=%b acc=%0d, want dz=0 acc=3", dz, $signed(acc));
    end
    issueGo(2'b11, 1'b1, 7'd0);
    waitDone(ob);
    e = sbQ.pop_front();
    nCompared++;
    if (!ob.got || {ob.acc, ob.ovf, ob.dz} !== {e.acc, e.ovf, e.dz}) begin
      nFailed++;
      $display("[TB] FAIL divzero_neg0: got=%0d acc=%0d dz=%b, want acc=%0d dz=1",
               ob.got, $signed(ob.acc), ob.dz, $signed(e.acc));
    end
  endtask

  task automatic test_reset_midop;
    exp_t e;
    obs_t ob;
    issueLoad(1'b0, 7'd9);
    issueGo(2'b10, 1'b0, 7'd9);
    repeat (4) @(posedge clki);
    #1 rst_n = 1'b0;
    #1;
    nCompared++;
    if (acc !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      nFailed++;
      $display("[TB] FAIL midop_reset: acc=%0d busy=%b done=%b, want 0 0 0", $signed(acc), busy, done);
    end
    sbQ.delete();
    modelAcc = '0;
    @(negedge clki); rst_n = 1'b1;
    issueLoad(1'b0, 7'd2);
    issueGo(2'b00, 1'b0, 7'd3);
    waitDone(ob);
    e = sbQ.pop_front();
    nCompared++;
    if (!ob.got || ob.acc !== e.acc || ob.acc !== 8'd5) begin
      nFailed++;
      $display("[TB] FAIL midop_recover: got=%0d acc=%0d, want acc=5", ob.got, $signed(ob.acc));
    end
  endtask

  task automatic test_load_go_priority;
    int doneSeen = 0;
    @(negedge clki); sinal = 1'b0; mag = 7'd4; op = 2'b00; load = 1'b1; go = 1'b1;
    @(negedge clki); load = 1'b0; go = 1'b0;
    modelAcc = 8'd4;
    repeat (3) begin
      if (done === 1'b1) doneSeen++;
      @(negedge clki);
    end
    nCompared++;
    if (acc !== modelAcc || doneSeen != 0) begin
      nFailed++;
      $display("[TB] FAIL load_go_priority: acc=%0d doneCycles=%0d, want acc=4 doneCycles=0", $signed(acc), doneSeen);
    end
  endtask

  task automatic test_busy_ignore;
    exp_t e;
    obs_t ob;
    issueLoad(1'b0, 7'd100);
    issueGo(2'b11, 1'b1, 7'd7);
    repeat (3) @(negedge clki);
    nCompared++;
    if (busy !== 1'b1) begin
      nFailed++;
      $display("[TB] FAIL ignore_busy: busy=%b mid-division, want 1", busy);
    end
    op = 2'b00; sinal = 1'b0; mag = 7'd50; go = 1'b1; load = 1'b1;
    @(negedge clki); go = 1'b0; load = 1'b0;
    waitDone(ob);
    e = sbQ.pop_front();
    nCompared++;
    if (!ob.got || {ob.acc, ob.ovf, ob.dz} !== {e.acc, e.ovf, e.dz} || ob.lat != e.lat - 4) begin
      nFailed++;
      $display("[TB] FAIL ignore_result: got=%0d acc=%0d ovf=%b lat=%0d, want acc=%0d ovf=%b lat=%0d",
               ob.got, $signed(ob.acc), ob.ovf, ob.lat, $signed(e.acc), e.ovf, e.lat - 4);
    end
    repeat (2) @(negedge clki);
    nCompared++;
    if (acc !== e.acc || done !== 1'b0) begin
      nFailed++;
      $display("[TB] FAIL ignore_after: acc=%0d done=%b, want acc=%0d done=0", $signed(acc), done, $signed(e.acc));
    end
  endtask

  initial begin
    test_reset();
    test_addsub();
    test_mul();
    test_div();
    test_div_zero();
    test_reset_midop();
    test_load_go_priority();
    test_busy_ignore();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/calc_engine.md
Name: calc_engine

Overview:
- Parametrised sequential arithmetic core for the calculator, successor to the fixed 8-bit combinational soma/sub/mul/div set.
- Holds a signed accumulator and takes a sign-magnitude operand from switches plus a sign switch.
- Performs add/sub in one cycle and multiply/divide as W-cycle iterative operations, with busy/done handshake and overflow/divide-by-zero flags.
- Sits between the operand input logic and the display driver.

Parameters:
W, 8, accumulator and operand width in bits, two's complement (operand magnitude is W-1 bits)

Ports:
clki  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
mag  in  W-1  operand magnitude
sinal  in  1  operand sign, 1 = negative
op  in  2  operation: 00 add, 01 sub, 10 mul, 11 div
load  in  1  pulse: acc <= operand
go  in  1  pulse: acc <= acc op operand
busy  out  1  high while a mul/div iteration is in progress
done  out  1  one-cycle pulse when acc holds a new go result
acc  out  W  signed accumulator
ovf  out  1  overflow on last go
dz  out  1  divide-by-zero on last go

Behaviour:
- Reset (async, rst_n=0): acc=0, busy=0, done=0, ovf=0, dz=0, FSM=IDLE. Takes effect immediately, including mid-operation; the partial result is discarded.
- Operand conversion: operand = sinal ? -{0,mag} : {0,mag}. mag=0 with sinal=1 gives 0.
- FSM states: IDLE, ITER, FIN.
  - IDLE: load has priority over go in the same cycle. load writes acc and clears ovf/dz; no done pulse.
  - go with op add/sub goes to FIN.
  - go with op mul/div and nonzero operand goes to ITER and latches op, |acc|, |operand| and the result sign.
  - ITER runs exactly W cycles, then goes to FIN.
  - FIN writes acc, ovf and dz, pulses done, and returns to IDLE.
- Timing: go sampled at edge E0.
  - add/sub and div-by-zero: acc/done valid after E1; busy stays 0.
  - mul/div: busy=1 after E0 through E_W; acc/done valid and busy=0 after E_{W+1}.
  - go or load while busy=1 is ignored, with no side effect.
- Add/sub: W-bit wrap. ovf=1 when the operands have the same sign (add) or different signs (sub) and the result sign differs from acc's sign.
- Mul: shift-add on magnitudes into a 2W-bit product, then sign applied. ovf=1 if the signed product is outside [-2^(W-1), 2^(W-1)-1]. acc takes the low W bits.
- Div: restoring division on magnitudes. Quotient truncates toward zero; sign = sign(acc) XOR sign(operand); remainder discarded. -2^(W-1)/-1 gives ovf=1 and acc=-2^(W-1).
- Div by zero: acc unchanged, dz=1, ovf=0, done pulses.
- ovf/dz hold until the next done or load.
- acc only changes at load or FIN.

Optional Feature:
- Macro CALC_SATURATE_EN.
- Defined: on ovf=1, acc is clamped to 2^(W-1)-1 for a positive true result or -2^(W-1) for a negative one. This applies to add, sub, mul and the -2^(W-1)/-1 division case.
- Undefined: acc wraps (low W bits); ovf flag behaviour is identical in both builds.

Test Plan:
1. W=8: load +100; go add +27 -> after E1 acc=127, ovf=0, done=1 for one cycle. Then go add +1 -> acc=-128, ovf=1 (with CALC_SATURATE_EN: acc=127, ovf=1).
2. load -12; go mul +10 -> busy high E0..E8, acc=-120, done at E9, ovf=0. Then go mul +2 -> acc=16 (low bits of -240), ovf=1 (saturated build: -128).
3. load +100; go div -7 -> acc=-14, done at E9. Then load -128; go div -1 -> ovf=1, acc=-128.
4. load +55; go div mag=0 -> after E1 acc=55, dz=1, busy never high. Then load +3 -> dz=0.
5. load +9; go mul +9; drop rst_n at E4 -> acc=0, busy=0, done=0 immediately. After release, load +2; go add +3 -> acc=5.
6. load and go asserted together with mag=4 -> acc=4, no done. go while busy during a div -> ignored; result matches the single operation.
